// File: rtl/main_memory_responder_pkg.sv
// Shared types and constants for the main memory responder and the caches that talk to it.
// The line width here must match the LINE_WIDTH parameter of main_memory_responder.
package main_memory_responder_pkg;

    localparam int MAIN_MEMORY_ADDR_WIDTH = 32;
    localparam int ICACHE_LINE_WIDTH      = 128;
    localparam int DCACHE_LINE_WIDTH      = ICACHE_LINE_WIDTH;
    localparam int MAIN_MEMORY_LATENCY    = 10;
    localparam int MAIN_MEMORY_NUM_LINES  = 1024;

    typedef struct packed {
        logic [MAIN_MEMORY_ADDR_WIDTH-1:0] addr;
        logic                              is_store;
        logic [DCACHE_LINE_WIDTH-1:0]      data;
    } memory_request_t;

    typedef enum logic {
        IC = 1'b0,
        DC = 1'b1
    } port_id_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

endpackage

// File: rtl/main_memory_arbiter.sv
// Two-way round-robin grant between the icache and dcache request ports.
// rr_last only moves when both ports competed, so a lone requester never steals the next turn.
module main_memory_arbiter
    import main_memory_responder_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     ic_valid,
    input  logic     dc_valid,
    input  logic     accept,
    output port_id_e grant,
    output logic     grant_valid
);

    port_id_e rr_last;

    // NOTE: every output gets a value before any branch, so no latch is inferred.
    always_comb begin
        grant       = IC;
        grant_valid = ic_valid | dc_valid;
        if (ic_valid && dc_valid) begin
            grant = (rr_last == IC) ? DC : IC;
        end else if (dc_valid) begin
            grant = DC;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_last <= IC;
        end else if (accept && ic_valid && dc_valid) begin
            rr_last <= grant;
        end
    end

endmodule

// File: rtl/main_memory_responder.sv
// Memory-side end of the cache miss protocol: one outstanding line request, fixed latency.
// Define MAIN_MEMORY_STORE_ACK_EN to make stores return an rsp_valid pulse like loads.
module main_memory_responder
    import main_memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = MAIN_MEMORY_ADDR_WIDTH,
    parameter int LINE_WIDTH  = ICACHE_LINE_WIDTH,
    parameter int NUM_LINES   = MAIN_MEMORY_NUM_LINES,
    parameter int MEM_LATENCY = MAIN_MEMORY_LATENCY
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ic_req_valid,
    input  memory_request_t       ic_req_info,
    output logic                  ic_rsp_valid,
    output logic [LINE_WIDTH-1:0] ic_rsp_data,
    input  logic                  dc_req_valid,
    input  memory_request_t       dc_req_info,
    output logic                  dc_rsp_valid,
    output logic [LINE_WIDTH-1:0] dc_rsp_data,
    output logic                  mem_busy
);

    localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
    localparam int INDEX_BITS  = $clog2(NUM_LINES);
    localparam int LAT_W       = $clog2(MEM_LATENCY + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LATENCY - 2);

`ifdef MAIN_MEMORY_STORE_ACK_EN
    localparam logic STORE_ACK = 1'b1;
`else
    localparam logic STORE_ACK = 1'b0;
`endif

    mem_state_e              state;
    logic [LAT_W-1:0]        lat_cnt;
    port_id_e                cur_port;
    logic [INDEX_BITS-1:0]   cur_index;
    logic                    cur_is_store;
    logic [LINE_WIDTH-1:0]   cur_data;
    logic [LINE_WIDTH-1:0]   mem [NUM_LINES];

    port_id_e                grant;
    logic                    grant_valid;
    logic                    accept;
    memory_request_t         req_sel;
    logic                    unused_addr_bits;

    main_memory_arbiter u_arbiter (
        .clock      (clock),
        .reset      (reset),
        .ic_valid   (ic_req_valid),
        .dc_valid   (dc_req_valid),
        .accept     (accept),
        .grant      (grant),
        .grant_valid(grant_valid)
    );

    // Requests are only looked at in IDLE, which keeps a held valid from re-capturing in RESP.
    assign accept  = (state == IDLE) && grant_valid;
    assign req_sel = (grant == DC) ? dc_req_info : ic_req_info;

    // Byte offset and upper address bits play no part in line selection.
    assign unused_addr_bits = ^{req_sel.addr[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS],
                                req_sel.addr[OFFSET_BITS-1:0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            lat_cnt      <= '0;
            cur_port     <= IC;
            cur_index    <= '0;
            cur_is_store <= 1'b0;
            cur_data     <= '0;
            ic_rsp_valid <= 1'b0;
            dc_rsp_valid <= 1'b0;
            ic_rsp_data  <= '0;
            dc_rsp_data  <= '0;
            mem_busy     <= 1'b0;
        end else begin
            ic_rsp_valid <= 1'b0;
            dc_rsp_valid <= 1'b0;
            ic_rsp_data  <= '0;
            dc_rsp_data  <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cur_port     <= grant;
                        cur_index    <= req_sel.addr[OFFSET_BITS +: INDEX_BITS];
                        cur_is_store <= req_sel.is_store;
                        cur_data     <= req_sel.data;
                        lat_cnt      <= LAT_INIT;
                        mem_busy     <= 1'b1;
                        state        <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= RESP;
                        // Outputs are registered, so the pulse is launched on entry to RESP.
                        if (!cur_is_store || STORE_ACK) begin
                            ic_rsp_valid <= (cur_port == IC);
                            dc_rsp_valid <= (cur_port == DC);
                            if (!cur_is_store && cur_port == IC) ic_rsp_data <= mem[cur_index];
                            if (!cur_is_store && cur_port == DC) dc_rsp_data <= mem[cur_index];
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                RESP: begin
                    mem_busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: storage has no reset; its contents survive reset and only stores change them.
    always_ff @(posedge clock) begin
        if (state == RESP && cur_is_store) begin
            mem[cur_index] <= cur_data;
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Randomized self-checking bench for main_memory_responder against a transaction-level model.
// Honors MAIN_MEMORY_STORE_ACK_EN the same way the design does.
module tb_main_memory_responder;
    import main_memory_responder_pkg::*;

    localparam int LAT   = MAIN_MEMORY_LATENCY;
    localparam int LINES = MAIN_MEMORY_NUM_LINES;
`ifdef MAIN_MEMORY_STORE_ACK_EN
    localparam bit STORE_ACK = 1'b1;
`else
    localparam bit STORE_ACK = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            ic_req_valid = 1'b0;
    logic            dc_req_valid = 1'b0;
    memory_request_t ic_req_info = '0;
    memory_request_t dc_req_info = '0;
    logic            ic_rsp_valid, dc_rsp_valid, mem_busy;
    logic [127:0]    ic_rsp_data, dc_rsp_data;

    int errors = 0;
    int checks = 0;

    // Reference model: line contents by index, and which port won the last contested grant.
    logic [127:0] ref_mem [int];
    int           written [$];
    bit           rr_last_dc = 1'b0;

    main_memory_responder dut (
        .clock       (clock),
        .reset       (reset),
        .ic_req_valid(ic_req_valid),
        .ic_req_info (ic_req_info),
        .ic_rsp_valid(ic_rsp_valid),
        .ic_rsp_data (ic_rsp_data),
        .dc_req_valid(dc_req_valid),
        .dc_req_info (dc_req_info),
        .dc_rsp_valid(dc_rsp_valid),
        .dc_rsp_data (dc_rsp_data),
        .mem_busy    (mem_busy)
    );

    always #5 clock = ~clock;

    function automatic int line_of(logic [31:0] a);
        return int'((a / 32'd16) % LINES);
    endfunction

    task automatic raise(input bit to_dc, input logic [31:0] a, input bit st, input logic [127:0] d);
        memory_request_t r;
        r.addr = a; r.is_store = st; r.data = d;
        if (to_dc) begin dc_req_info = r; dc_req_valid = 1'b1; end
        else       begin ic_req_info = r; ic_req_valid = 1'b1; end
    endtask

    // Called at a negedge with the DUT idle and at least one valid raised; serves one request.
    task automatic serve_one(input string tag, output bit got_dc);
        bit g_dc, pulse;
        memory_request_t r;
        int line, drop_k;
        logic [127:0] exp_data;
        if (ic_req_valid && dc_req_valid) begin
            g_dc = !rr_last_dc;
            rr_last_dc = g_dc;
        end else begin
            g_dc = dc_req_valid;
        end
        r = g_dc ? dc_req_info : ic_req_info;
        line = line_of(r.addr);
        pulse = !r.is_store || STORE_ACK;
        exp_data = (!r.is_store && ref_mem.exists(line)) ? ref_mem[line] : '0;
        drop_k = (r.is_store && !STORE_ACK) ? 1 : LAT + 1;
        got_dc = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clock);
            checks += 3;
            if (ic_rsp_valid !== (pulse && k == LAT && !g_dc)) begin
                errors++; $display("FAIL %s c%0d ic_rsp_valid got %0b exp %0b", tag, k, ic_rsp_valid, pulse && k == LAT && !g_dc);
            end
            if (dc_rsp_valid !== (pulse && k == LAT && g_dc)) begin
                errors++; $display("FAIL %s c%0d dc_rsp_valid got %0b exp %0b", tag, k, dc_rsp_valid, pulse && k == LAT && g_dc);
            end
            if (mem_busy !== (k <= LAT)) begin
                errors++; $display("FAIL %s c%0d mem_busy got %0b exp %0b", tag, k, mem_busy, k <= LAT);
            end
            checks++;
            if ((g_dc ? ic_rsp_data : dc_rsp_data) !== 128'd0) begin
                errors++; $display("FAIL %s c%0d idle port data got %h exp 0", tag, k, g_dc ? ic_rsp_data : dc_rsp_data);
            end
            if (k == LAT && pulse) begin
                checks++;
                if ((g_dc ? dc_rsp_data : ic_rsp_data) !== exp_data) begin
                    errors++; $display("FAIL %s rsp_data got %h exp %h", tag, g_dc ? dc_rsp_data : ic_rsp_data, exp_data);
                end
            end
            if (dc_rsp_valid === 1'b1) got_dc = 1'b1;
            if (k == drop_k) begin
                if (g_dc) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
            end
        end
        if (r.is_store) begin
            if (!ref_mem.exists(line)) written.push_back(line);
            ref_mem[line] = r.data;
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
        rr_last_dc = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks += 5;
        if (ic_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset ic_rsp_valid got %b exp 0", ic_rsp_valid); end
        if (dc_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset dc_rsp_valid got %b exp 0", dc_rsp_valid); end
        if (ic_rsp_data !== 128'd0) begin errors++; $display("FAIL reset ic_rsp_data got %h exp 0", ic_rsp_data); end
        if (dc_rsp_data !== 128'd0) begin errors++; $display("FAIL reset dc_rsp_data got %h exp 0", dc_rsp_data); end
        if (mem_busy !== 1'b0) begin errors++; $display("FAIL reset mem_busy got %b exp 0", mem_busy); end
        reset = 1'b1;
    endtask

    task automatic test_ic_load();
        bit g;
        raise(1'b1, 32'h40, 1'b1, {16{8'hA5}});
        serve_one("preload_a5", g);
        raise(1'b0, 32'h40, 1'b0, '0);
        serve_one("ic_load_40", g);
    endtask

    task automatic test_wrap();
        bit g;
        raise(1'b0, 32'h0001_0040, 1'b0, '0);
        serve_one("wrap_10040", g);
        raise(1'b0, 32'h0000_004C, 1'b0, '0);
        serve_one("offset_4c", g);
    endtask

    task automatic test_store_load();
        bit g;
        raise(1'b1, 32'h80, 1'b1, 128'h1234);
        serve_one("dc_store_80", g);
        raise(1'b0, 32'h80, 1'b0, '0);
        serve_one("ic_load_80", g);
    endtask

    // Both ports held continuously after a reset: grants must go DC, IC, DC, IC.
    task automatic test_back_to_back();
        bit g;
        bit exp_dc;
        apply_reset();
        raise(1'b0, 32'h40, 1'b0, '0);
        raise(1'b1, 32'h80, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            exp_dc = (i % 2 == 0);
            serve_one("rr_pair", g);
            checks++;
            if (g !== exp_dc) begin
                errors++; $display("FAIL rr_order step%0d dc_served got %0b exp %0b", i, g, exp_dc);
            end
            if (i < 3) begin
                if (exp_dc) raise(1'b1, 32'h80, 1'b0, '0);
                else        raise(1'b0, 32'h40, 1'b0, '0);
            end
        end
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit g;
        raise(1'b0, 32'h40, 1'b0, '0);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        #1;
        checks += 3;
        if (mem_busy !== 1'b0) begin errors++; $display("FAIL midreset mem_busy got %b exp 0", mem_busy); end
        if (ic_rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset ic_rsp_valid got %b exp 0", ic_rsp_valid); end
        if (dc_rsp_valid !== 1'b0) begin errors++; $display("FAIL midreset dc_rsp_valid got %b exp 0", dc_rsp_valid); end
        ic_req_valid = 1'b0;
        rr_last_dc = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < LAT + 3; k++) begin
            @(negedge clock);
            checks++;
            if (ic_rsp_valid !== 1'b0 || mem_busy !== 1'b0) begin
                errors++; $display("FAIL after_reset c%0d ic_rsp_valid=%b mem_busy=%b exp 0/0", k, ic_rsp_valid, mem_busy);
            end
        end
        raise(1'b0, 32'h80, 1'b0, '0);
        serve_one("post_reset_load", g);
    endtask

    task automatic test_random();
        bit g, want_ic, want_dc, st;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            want_ic = $urandom_range(0, 1) == 1;
            want_dc = $urandom_range(0, 1) == 1;
            if (!want_ic && !want_dc) want_dc = 1'b1;
            if (want_ic) begin
                a = 32'(written[$urandom_range(0, written.size() - 1)]) * 32'd16
                    + 32'($urandom_range(0, 15)) + (32'($urandom_range(0, 7)) << 14);
                raise(1'b0, a, 1'b0, '0);
            end
            if (want_dc) begin
                st = $urandom_range(0, 1) == 1;
                if (st) a = 32'($urandom_range(0, 15)) * 32'd16 + (32'($urandom_range(0, 3)) << 14);
                else    a = 32'(written[$urandom_range(0, written.size() - 1)]) * 32'd16;
                raise(1'b1, a, st, {$urandom(), $urandom(), $urandom(), $urandom()});
            end
            serve_one("random", g);
            if (ic_req_valid || dc_req_valid) serve_one("random_held", g);
        end
    endtask

    initial begin
        test_reset();
        test_ic_load();
        test_wrap();
        test_store_load();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
